// File: rtl/go_done_seq_pkg.sv
// Shared types and default widths for the go/done sequencer.
`default_nettype none

package go_done_seq_pkg;

  localparam int DEF_CNT_W = 64;
  localparam int DEF_RUN_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RST  = 3'd1,
    ST_GO   = 3'd2,
    ST_GAP  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  typedef logic [DEF_CNT_W-1:0] count_t;

endpackage

`default_nettype wire

// File: rtl/go_done_sequencer_cycle_counter.sv
// Clear/enable up-counter exposing its incremented value and a compare against a limit.
`default_nettype none

module cycle_counter
  import go_done_seq_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic         limit_en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] next_count,
  output logic         at_limit
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= next_count;
    end
  end

  // The compare looks at the value this cycle would reach, so a hit ends the phase on time.
  assign next_count = count + ONE;
  assign at_limit   = limit_en && (next_count == limit);

endmodule

`default_nettype wire

// File: rtl/go_done_sequencer.sv
// Drives a component through reset, go and done for N back-to-back runs with an optional cycle limit.
// Build option GO_DONE_SEQ_RERESET_EN: re-enter the reset phase between runs instead of a one-cycle gap.
`default_nettype none

module go_done_sequencer
  import go_done_seq_pkg::*;
#(
  parameter int RESET_CYCLES = 3,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int RUN_W        = DEF_RUN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] cycle_limit,
  input  logic [RUN_W-1:0] num_runs,
  output logic             dut_reset,
  output logic             dut_go,
  input  logic             dut_done,
  output logic             busy,
  output logic             finished,
  output logic             timed_out,
  output logic [CNT_W-1:0] run_cycles,
  output logic [CNT_W-1:0] total_cycles,
  output logic [RUN_W-1:0] run_idx
);

  localparam logic [CNT_W-1:0] RST_LIMIT = CNT_W'(RESET_CYCLES);
  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);

  state_t           state;
  logic [CNT_W-1:0] limit_r;
  logic [RUN_W-1:0] runs_r;
  logic [CNT_W-1:0] rst_next;
  logic [CNT_W-1:0] go_next;
  logic             rst_hit;
  logic             go_hit;
  logic             last_run;
  logic             unused_rst_next;

  cycle_counter #(.W(CNT_W)) u_rst_cnt (
    .clk        (clk),
    .reset      (reset),
    .clear      (state != ST_RST),
    .enable     (state == ST_RST),
    .limit_en   (1'b1),
    .limit      (RST_LIMIT),
    .next_count (rst_next),
    .at_limit   (rst_hit)
  );

  cycle_counter #(.W(CNT_W)) u_go_cnt (
    .clk        (clk),
    .reset      (reset),
    .clear      (state != ST_GO),
    .enable     (state == ST_GO),
    .limit_en   (limit_r != '0),
    .limit      (limit_r),
    .next_count (go_next),
    .at_limit   (go_hit)
  );

  assign unused_rst_next = ^rst_next;
  assign last_run        = ((run_idx + RUN_ONE) == runs_r);

`ifdef GO_DONE_SEQ_RERESET_EN
  logic rerun;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      dut_reset    <= 1'b1;
      dut_go       <= 1'b0;
      busy         <= 1'b0;
      finished     <= 1'b0;
      timed_out    <= 1'b0;
      run_cycles   <= '0;
      total_cycles <= '0;
      run_idx      <= '0;
      limit_r      <= '0;
      runs_r       <= RUN_ONE;
`ifdef GO_DONE_SEQ_RERESET_EN
      rerun        <= 1'b0;
`endif
    end else begin
      finished <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_RST;
            limit_r      <= cycle_limit;
            runs_r       <= (num_runs == '0) ? RUN_ONE : num_runs;
            timed_out    <= 1'b0;
            total_cycles <= '0;
            run_idx      <= '0;
            busy         <= 1'b1;
            dut_reset    <= 1'b1;
            dut_go       <= 1'b0;
`ifdef GO_DONE_SEQ_RERESET_EN
            rerun        <= 1'b0;
`endif
          end
        end
        ST_RST: begin
          if (rst_hit) begin
            state     <= ST_GO;
            dut_reset <= 1'b0;
            dut_go    <= 1'b1;
`ifdef GO_DONE_SEQ_RERESET_EN
            if (rerun) begin
              run_idx <= run_idx + RUN_ONE;
              rerun   <= 1'b0;
            end
`endif
          end
        end
        ST_GO: begin
          // Done takes priority over the limit when both land on the same cycle.
          if (dut_done || go_hit) begin
            run_cycles   <= go_next;
            total_cycles <= total_cycles + go_next;
            dut_go       <= 1'b0;
            if (!dut_done || last_run) begin
              state     <= ST_FIN;
              dut_reset <= 1'b1;
              finished  <= 1'b1;
              timed_out <= !dut_done;
            end else begin
`ifdef GO_DONE_SEQ_RERESET_EN
              state     <= ST_RST;
              dut_reset <= 1'b1;
              rerun     <= 1'b1;
`else
              state     <= ST_GAP;
`endif
            end
          end
        end
        ST_GAP: begin
          state   <= ST_GO;
          dut_go  <= 1'b1;
          run_idx <= run_idx + RUN_ONE;
        end
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_go_done_sequencer.sv
// Randomized bench: per-sequence outcome predicted from run/limit/done rules, compared to the observed trace.
`default_nettype none

module tb_go_done_sequencer;

  localparam int R     = 3;
  localparam int CNT_W = 64;
  localparam int RUN_W = 8;
`ifdef GO_DONE_SEQ_RERESET_EN
  localparam int GAP_LEN = R;
  localparam bit RERESET = 1'b1;
`else
  localparam int GAP_LEN = 1;
  localparam bit RERESET = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] cycle_limit;
  logic [RUN_W-1:0] num_runs;
  logic             dut_reset;
  logic             dut_go;
  logic             dut_done;
  logic             busy;
  logic             finished;
  logic             timed_out;
  logic [CNT_W-1:0] run_cycles;
  logic [CNT_W-1:0] total_cycles;
  logic [RUN_W-1:0] run_idx;

  go_done_sequencer #(.RESET_CYCLES(R), .CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cycle_limit  (cycle_limit),
    .num_runs     (num_runs),
    .dut_reset    (dut_reset),
    .dut_go       (dut_go),
    .dut_done     (dut_done),
    .busy         (busy),
    .finished     (finished),
    .timed_out    (timed_out),
    .run_cycles   (run_cycles),
    .total_cycles (total_cycles),
    .run_idx      (run_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_at[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Launch one sequence; done_at[i] is the go cycle on which run i raises done (0 = never).
  task automatic run_seq(input int runs, input longint unsigned lim, input bit inject_start);
    int nr, n, d, ptr, gocnt, rst_seen, gap_seen, go_seen, fin_t, exp_fin;
    longint unsigned c, sum, last;
    bit to, prev_go;

    nr = (runs == 0) ? 1 : runs;
    n = 0; sum = 0; last = 0; to = 1'b0;
    for (int i = 0; i < nr; i++) begin
      d = done_at[i];
      if (lim != 0 && (d == 0 || longint'(d) > longint'(lim))) begin
        c  = lim;
        to = 1'b1;
      end else begin
        c = longint'(d);
      end
      sum += c;
      last = c;
      n++;
      if (to) break;
    end
    exp_fin = 1 + R + int'(sum) + (n - 1) * GAP_LEN;

    @(negedge clk);
    start       = 1'b1;
    cycle_limit = lim;
    num_runs    = RUN_W'(runs);
    dut_done    = 1'b0;
    ptr = 0; gocnt = 0; prev_go = 1'b0; fin_t = -1;
    rst_seen = 0; gap_seen = 0; go_seen = 0;

    for (int t = 1; t <= 400 && fin_t < 0; t++) begin
      @(negedge clk);
      start = inject_start && ($urandom_range(0, 3) == 0);
      if (t == 1) check("busy_after_start", busy, 1);
      if (dut_go) begin
        gocnt++;
        go_seen++;
        if (gocnt == 1) check("run_idx_at_go", run_idx, ptr);
        dut_done = (ptr < done_at.size()) && (done_at[ptr] != 0) && (gocnt == done_at[ptr]);
      end else begin
        if (prev_go) begin
          ptr++;
          gocnt = 0;
        end
        dut_done = 1'($urandom_range(0, 1));
      end
      prev_go = dut_go;
      if (dut_reset && !finished) rst_seen++;
      if (busy && !dut_go && !dut_reset) gap_seen++;
      if (finished) fin_t = t;
    end

    if (fin_t < 0) check("finish_within_budget", 0, 1);
    check("latency", fin_t, exp_fin);
    check("run_cycles", run_cycles, last);
    check("total_cycles", total_cycles, sum);
    check("timed_out", timed_out, to);
    check("run_idx_final", run_idx, n - 1);
    check("go_cycles", go_seen, sum);
    check("reset_cycles", rst_seen, RERESET ? R * n : R);
    check("gap_cycles", gap_seen, RERESET ? 0 : n - 1);

    @(negedge clk);
    start    = 1'b0;
    dut_done = 1'b0;
    check("finished_one_cycle", finished, 0);
    check("idle_busy", busy, 0);
    check("idle_outputs", {dut_reset, dut_go}, 2'b10);
    check("hold_total", total_cycles, sum);
    @(negedge clk);
    check("fin_start_dropped", busy, 0);
  endtask

  initial begin
    int runs, k;
    longint unsigned lim;

    reset = 1'b1; start = 1'b0; dut_done = 1'b0; cycle_limit = '0; num_runs = '0;
    repeat (3) @(negedge clk);
    check("rst_dut_reset", dut_reset, 1);
    check("rst_dut_go", dut_go, 0);
    check("rst_busy", busy, 0);
    check("rst_finished", finished, 0);
    check("rst_timed_out", timed_out, 0);
    check("rst_counts", {run_cycles, total_cycles}, 0);
    check("rst_run_idx", run_idx, 0);
    reset = 1'b0;

    done_at = '{5};       run_seq(1, 0, 1'b0);
    done_at = '{2, 4, 1}; run_seq(3, 0, 1'b1);
    done_at = '{0};       run_seq(1, 4, 1'b0);
    done_at = '{4};       run_seq(1, 4, 1'b0);
    done_at = '{1, 1};    run_seq(2, 0, 1'b0);
    done_at = '{3};       run_seq(0, 0, 1'b0);

    // Abort on the second go cycle with a synchronous reset.
    @(negedge clk);
    start = 1'b1; cycle_limit = '0; num_runs = 8'd1; dut_done = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    for (int t = 0; t < 50 && k < 2; t++) begin
      if (dut_go) k++;
      if (k == 1) start = 1'b1;
      if (k < 2) @(negedge clk);
    end
    check("abort_reached_go2", k, 2);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("abort_outputs", {dut_go, dut_reset, busy, finished}, 4'b0100);
    check("abort_run_idx", run_idx, 0);
    @(negedge clk);
    reset = 1'b0;
    check("abort_no_finish", finished, 0);

    for (int s = 0; s < 30; s++) begin
      runs = $urandom_range(0, 4);
      lim  = ($urandom_range(0, 2) == 0) ? 0 : longint'($urandom_range(1, 6));
      done_at.delete();
      for (int i = 0; i < ((runs == 0) ? 1 : runs); i++) begin
        k = $urandom_range(1, 7);
        if (lim != 0 && $urandom_range(0, 3) == 0) k = 0;
        done_at.push_back(k);
      end
      run_seq(runs, lim, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
